// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and ALU-control decode.
// Holds one decoded instruction for the EX stage. Resolves RAW hazards
// against EX/MEM and MEM/WB results, and drives the ALU operands/opcode
// together with the control bits and store data headed toward MEM.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [1:0]            id_alu_class,
    input  logic [2:0]            id_funct3,
    input  logic                  id_funct7_5,
    input  logic                  id_a_sel_pc,
    input  logic                  id_b_sel_imm,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [3:0]            alu_sel,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [XLEN-1:0]       ex_pc
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_t;

    logic                  valid_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       rs1_data_q;
    logic [XLEN-1:0]       rs2_data_q;
    logic [XLEN-1:0]       imm_q;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [1:0]            alu_class_q;
    logic [2:0]            funct3_q;
    logic                  funct7_5_q;
    logic                  a_sel_pc_q;
    logic                  b_sel_imm_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;

    logic [XLEN-1:0]       fwd_rs1;
    logic [XLEN-1:0]       fwd_rs2;
    alu_op_t               alu_op;

    // Pipeline register: reset/flush insert a bubble, stall refreshes operands, otherwise load from ID
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_class_q <= '0;
            funct3_q    <= '0;
            funct7_5_q  <= 1'b0;
            a_sel_pc_q  <= 1'b0;
            b_sel_imm_q <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (stall) begin
            rs1_data_q <= fwd_rs1;
            rs2_data_q <= fwd_rs2;
        end else begin
            valid_q     <= id_valid;
            pc_q        <= id_pc;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            alu_class_q <= id_alu_class;
            funct3_q    <= id_funct3;
            funct7_5_q  <= id_funct7_5;
            a_sel_pc_q  <= id_a_sel_pc;
            b_sel_imm_q <= id_b_sel_imm;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
            mem_write_q <= id_mem_write;
        end
    end

    // Forwarding muxes: the younger EX/MEM result overrides MEM/WB; x0 never forwards
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
            fwd_rs1 = memwb_result;
        end
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q)) begin
            fwd_rs1 = exmem_result;
        end
        fwd_rs2 = rs2_data_q;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
            fwd_rs2 = memwb_result;
        end
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q)) begin
            fwd_rs2 = exmem_result;
        end
    end

    // ALU opcode decode; funct7_5 selects SUB only for R-type, SRA for both shift forms
    always_comb begin
        alu_op = ALU_ADD;
        case (alu_class_q)
            2'b00: alu_op = ALU_ADD;
            2'b01: alu_op = ALU_SUB;
            default: begin
                case (funct3_q)
                    3'b000:  alu_op = (alu_class_q == 2'b10 && funct7_5_q) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_5_q ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
        endcase
    end

    assign alu_a         = a_sel_pc_q ? pc_q : fwd_rs1;
    assign alu_b         = b_sel_imm_q ? imm_q : fwd_rs2;
    assign alu_sel       = alu_op;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_mem_read   = mem_read_q & valid_q;
    assign ex_mem_write  = mem_write_q & valid_q;
    assign ex_store_data = fwd_rs2;
    assign ex_pc         = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver issues directed and random
// cycles, predicts the stage outputs from a behavioural model and queues
// them; an independent monitor samples the DUT and compares.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_alu_class;
    logic [2:0]  id_funct3;
    logic        id_funct7_5, id_a_sel_pc, id_b_sel_imm;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]  alu_sel;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  cls;
        logic [2:0]  f3;
        logic        f7, a_pc, b_imm, rw, mr, mw;
    } stage_t;

    typedef struct {
        logic [31:0] a, b, store, pc;
        logic [3:0]  sel;
        logic        valid, rw, mr, mw;
        logic [4:0]  rd;
    } exp_t;

    stage_t model;
    bit     model_known = 0;
    exp_t   exp_q[$];

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_class(id_alu_class), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Value an operand sees this cycle: newest in-flight producer wins, x0 is never produced
    function automatic logic [31:0] operand_value(logic [4:0] src, logic [31:0] held);
        if (src == 5'd0) return held;
        if (exmem_reg_write && exmem_rd == src) return exmem_result;
        if (memwb_reg_write && memwb_rd == src) return memwb_result;
        return held;
    endfunction

    // Opcode the ALU should perform for a given class/funct combination
    function automatic logic [3:0] expected_op(logic [1:0] cls, logic [2:0] f3, logic f7);
        logic [3:0] by_funct3 [8];
        logic [3:0] op;
        by_funct3 = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd6, 4'd7};
        if (cls == 2'b00) return 4'd0;
        if (cls == 2'b01) return 4'd1;
        op = by_funct3[f3];
        if (f3 == 3'd0 && cls == 2'b10 && f7) op = 4'd1;
        if (f3 == 3'd5 && f7) op = 4'd9;
        return op;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic quiet();
        rst = 0; stall = 0; flush = 0;
        id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_class = '0; id_funct3 = '0;
        id_funct7_5 = 0; id_a_sel_pc = 0; id_b_sel_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic random_id();
        id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
        id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom); id_alu_class = 2'($urandom); id_funct3 = 3'($urandom);
        id_funct7_5 = 1'($urandom); id_a_sel_pc = 1'($urandom); id_b_sel_imm = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
    endtask

    task automatic random_inputs();
        random_id();
        rst   = ($urandom_range(0, 99) < 3);
        flush = ($urandom_range(0, 99) < 8);
        stall = ($urandom_range(0, 99) < 30);
        exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
    endtask

    // Predict this cycle's outputs, queue them, then advance the model past the next edge
    task automatic commit_cycle();
        exp_t   e;
        stage_t nxt;
        logic [31:0] v1, v2;
        v1 = operand_value(model.rs1, model.rs1_data);
        v2 = operand_value(model.rs2, model.rs2_data);
        if (model_known) begin
            e.a     = model.a_pc ? model.pc : v1;
            e.b     = model.b_imm ? model.imm : v2;
            e.store = v2;
            e.pc    = model.pc;
            e.sel   = expected_op(model.cls, model.f3, model.f7);
            e.valid = model.valid;
            e.rd    = model.rd;
            e.rw    = model.rw && model.valid;
            e.mr    = model.mr && model.valid;
            e.mw    = model.mw && model.valid;
            exp_q.push_back(e);
        end
        nxt = model;
        if (rst || flush) begin
            nxt = '{valid: 0, pc: 0, rs1_data: 0, rs2_data: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
                    cls: 0, f3: 0, f7: 0, a_pc: 0, b_imm: 0, rw: 0, mr: 0, mw: 0};
        end else if (stall) begin
            nxt.rs1_data = v1;
            nxt.rs2_data = v2;
        end else begin
            nxt = '{valid: id_valid, pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                    imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, cls: id_alu_class,
                    f3: id_funct3, f7: id_funct7_5, a_pc: id_a_sel_pc, b_imm: id_b_sel_imm,
                    rw: id_reg_write, mr: id_mem_read, mw: id_mem_write};
        end
        if (rst) model_known = 1;
        if (model_known) model = nxt;
    endtask

    // Monitor: once settled after each falling edge, compare the DUT against the oldest prediction
    task automatic checkOutput();
        exp_t e;
        e = exp_q.pop_front();
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("alu_sel", 32'(alu_sel), 32'(e.sel));
        check("ex_valid", 32'(ex_valid), 32'(e.valid));
        check("ex_rd", 32'(ex_rd), 32'(e.rd));
        check("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
        check("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        check("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
        check("ex_store_data", ex_store_data, e.store);
        check("ex_pc", ex_pc, e.pc);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput();
        end
    end

    // Driver: directed scenarios first, then a long random run
    initial begin
        quiet();
        rst = 1;

        // Reset while ID presents a live instruction
        applyStimulus(); random_id(); rst = 1; id_valid = 1; id_reg_write = 1;
        id_rs1 = 5'd3; id_rd = 5'd9; id_alu_class = 2'b10; commit_cycle();

        // R-type SUB
        applyStimulus(); quiet(); id_valid = 1; id_alu_class = 2'b10; id_funct3 = 3'b000;
        id_funct7_5 = 1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs1_data = 32'h0000000A;
        id_rs2_data = 32'h00000003; id_rd = 5'd4; id_reg_write = 1; commit_cycle();

        // Forwarding priority, then MEM/WB only once EX/MEM targets x0
        applyStimulus(); quiet(); id_valid = 1; id_rs1 = 5'd5; id_rs1_data = 32'h55555555;
        id_alu_class = 2'b10; commit_cycle();
        applyStimulus(); quiet(); stall = 1;
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h11111111;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h22222222; commit_cycle();
        applyStimulus(); quiet(); stall = 1;
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'h11111111;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h22222222; commit_cycle();

        // x0 never forwards
        applyStimulus(); quiet(); id_valid = 1; id_alu_class = 2'b10; commit_cycle();
        applyStimulus(); quiet(); memwb_reg_write = 1; memwb_rd = 5'd0;
        memwb_result = 32'hCAFEF00D; stall = 1; commit_cycle();

        // Operand refresh survives a retiring writer while stalled
        applyStimulus(); quiet(); id_valid = 1; id_rs2 = 5'd7; id_rs2_data = 32'h0;
        id_mem_write = 1; commit_cycle();
        applyStimulus(); quiet(); random_id(); stall = 1;
        memwb_reg_write = 1; memwb_rd = 5'd7; memwb_result = 32'hDEADBEEF; commit_cycle();
        applyStimulus(); quiet(); random_id(); stall = 1; commit_cycle();
        applyStimulus(); quiet(); random_id(); stall = 1; commit_cycle();

        // Flush wins over stall
        applyStimulus(); quiet(); random_id(); stall = 1; flush = 1; commit_cycle();

        // SRAI and ADDI with bit 30 set
        applyStimulus(); quiet(); id_valid = 1; id_alu_class = 2'b11; id_funct3 = 3'b101;
        id_funct7_5 = 1; id_b_sel_imm = 1; id_imm = 32'd4; commit_cycle();
        applyStimulus(); quiet(); id_valid = 1; id_alu_class = 2'b11; id_funct3 = 3'b000;
        id_funct7_5 = 1; id_b_sel_imm = 1; id_imm = 32'hFFFFFFFF; commit_cycle();

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(); random_inputs(); commit_cycle();
        end

        applyStimulus(); quiet(); commit_cycle();
        applyStimulus(); quiet(); commit_cycle();
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
